hex_keypad_entry: RTL and testbench
===================================

// Module: hex_keypad_entry
// PURPOSE
//  Input-side counterpart of the 8-digit hex seven-segment display driver.
//  Scans a 4x4 hex keypad and debounces it. Each accepted key press is shifted into a 32-bit operand register.
//  That register feeds the display and ALU operand inputs, so the user types digits and sees them immediately.
// PARAMETERS
//  SCAN_DIV_W      11  width of free-running divider; a scan tick fires when the divider is all-ones
//  DEBOUNCE_SCANS  4   consecutive identical full scans needed to accept a press or a release (1..15)
// PORTS
//  clk          in   1   system clock, all flops on posedge
//  rst          in   1   asynchronous, active-high reset
//  row          in   4   keypad rows, active-low (pulled up), asynchronous to clk
//  clear        in   1   synchronous clear of value and digit_count
//  col          out  4   keypad column drive, active-low one-hot
//  value        out  32  entered operand; newest digit in [3:0]
//  key_code     out  4   code of the last accepted key
//  key_valid    out  1   one-clk pulse per accepted press
//  digit_count  out  4   digits entered since reset/clear, saturates at 8
// BEHAVIOUR
//  Reset values: col=4'b1110, value=0, key_code=0, key_valid=0, digit_count=0.
//   Also on reset: divider=0, col_idx=0, state=IDLE, debounce count=0.
//  row passes through a 2-flop synchronizer before use.
//  Divider: +1 every clk and wraps. tick = &divider.
//  On tick:
//   - sample the synchronized row for the current col_idx,
//   - then advance col_idx 0->1->2->3->0; col = ~(4'b0001 << col_idx).
//   - A full scan completes on the tick where col_idx==3.
//  Per full scan, classify the result:
//   - NONE: no row low in any column.
//   - SINGLE: exactly one row/col pair low; code = {row_idx[1:0], col_idx[1:0]}.
//   - MULTI: any other pattern.
//  FSM (evaluated at scan completion only):
//   IDLE:    SINGLE -> DEBOUNCE; cand=code, cnt=1. Otherwise stay.
//   DEBOUNCE:
//    - SINGLE same cand: cnt+1. When cnt reaches DEBOUNCE_SCANS, ACCEPT and go to HELD.
//    - SINGLE different code: restart with the new cand, cnt=1.
//    - NONE or MULTI: go to IDLE.
//   HELD:    NONE -> RELEASE with cnt=1. SINGLE or MULTI stays HELD. No rollover: a second key is ignored.
//   RELEASE:
//    - NONE: cnt+1. When cnt reaches DEBOUNCE_SCANS, go to IDLE.
//    - Anything else: back to HELD.
//  DEBOUNCE_SCANS=1 accepts on the first SINGLE scan; the DEBOUNCE state is skipped.
//  ACCEPT (registered, visible the clk after the scan-completing tick):
//   key_valid=1 for exactly one clk, key_code=cand, value={value[27:0],cand}.
//   digit_count=min(digit_count+1,8). Once 8 digits are held, the oldest digit is shifted out.
//  clear=1: value=0 and digit_count=0 next clk. Scan and FSM are unaffected.
//  clear and ACCEPT in the same clk: clear wins for value/digit_count. key_valid and key_code still update.
//  A held key produces exactly one key_valid regardless of hold time.
//  Reset mid-scan or mid-debounce returns every flop to its reset value; no partial key is emitted.
// STRUCTURE
//  Package keypad_pkg:
//   - state encoding IDLE/DEBOUNCE/HELD/RELEASE (2 bits),
//   - scan-class encoding NONE/SINGLE/MULTI,
//   - constants COL_IDLE=4'b1110, MAX_DIGITS=8.
//  Sub-module sync_2ff (4-bit two-flop synchronizer with async rst, reset value 4'b1111).
//  Divider, column scan, classifier, FSM and the value shift register stay in this module.
// TESTING  (run with SCAN_DIV_W=3, DEBOUNCE_SCANS=4; a scan = 4 ticks = 32 clk)
//  1 Assert rst mid-run -> col=1110, value=0, digit_count=0, key_valid=0 while rst is high.
//    After release, col walks 1110,1101,1011,0111 every 8 clk.
//  2 Press row1/col2 for 6 scans, then release -> exactly one key_valid, key_code=4'h6, value=32'h6, digit_count=1.
//  3 Bounce: press row0/col1 for 2 scans, NONE for 1, press 4 scans -> a single key_valid (code 4'h1) only after the 4th stable scan.
//  4 Enter codes 1..9 with full release between each -> value=32'h23456789, digit_count=8 (saturated), 9 pulses.
//  5 Hold row0/col0 and row2/col3 together for 10 scans -> no key_valid.
//    Then press row3/col3 alone -> key_code=4'hF.
//  6 Assert clear in the same clk as an accept of code 4'hA -> value=0, digit_count=0, key_valid=1, key_code=4'hA.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared encodings for the hex keypad entry block: FSM states, scan classes
// and the fixed column/digit constants.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } scan_class_t;

  localparam logic [3:0] COL_IDLE   = 4'b1110;
  localparam logic [3:0] MAX_DIGITS = 4'd8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the 4 keypad row lines; idles high (no key
// pressed) out of reset.
module sync_2ff (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 4'b1111;
      q    <= 4'b1111;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner with debounce; accepted keys shift into a 32-bit
// operand register that feeds the display and ALU.
module hex_keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_W     = 11,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  input  logic        clear,
  output logic [3:0]  col,
  output logic [31:0] value,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [3:0]  digit_count
);

  localparam logic [3:0] DS_CNT = 4'(DEBOUNCE_SCANS);

  logic [3:0]            row_sync;
  logic [SCAN_DIV_W-1:0] divider;
  logic                  tick;
  logic [1:0]            col_idx;
  logic                  scan_done;

  // Per-scan accumulation: low count saturates at 2 (anything >1 is MULTI).
  logic [1:0]  acc_cnt;
  logic [3:0]  acc_code;
  logic [1:0]  cur_cnt, base_cnt, scan_cnt;
  logic [1:0]  cur_row;
  logic [3:0]  base_code, scan_code;
  logic [2:0]  sum_cnt;
  scan_class_t scan_class;

  state_t      state, state_n;
  logic [3:0]  cand, cand_n;
  logic [3:0]  cnt, cnt_n;
  logic        accept;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (row_sync)
  );

  assign tick      = &divider;
  assign scan_done = tick && (col_idx == 2'd3);
  assign col       = ~((~COL_IDLE) << col_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divider  <= '0;
      col_idx  <= 2'd0;
      acc_cnt  <= 2'd0;
      acc_code <= 4'd0;
    end else begin
      divider <= divider + SCAN_DIV_W'(1);
      if (tick) begin
        col_idx  <= col_idx + 2'd1;
        acc_cnt  <= scan_cnt;
        acc_code <= scan_code;
      end
    end
  end

  // Fold the current column's sample into the running scan result; column 0
  // starts a fresh scan so the stored accumulator is ignored there.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and a latch is never inferred.
    cur_cnt = 2'd0;
    cur_row = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync[r]) begin
        if (cur_cnt != 2'd2) cur_cnt = cur_cnt + 2'd1;
        cur_row = 2'(r);
      end
    end
    base_cnt  = (col_idx == 2'd0) ? 2'd0 : acc_cnt;
    base_code = (col_idx == 2'd0) ? 4'd0 : acc_code;
    sum_cnt   = {1'b0, base_cnt} + {1'b0, cur_cnt};
    scan_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
    scan_code = (base_cnt == 2'd0 && cur_cnt == 2'd1) ? {cur_row, col_idx} : base_code;
    case (scan_cnt)
      2'd0:    scan_class = NONE;
      2'd1:    scan_class = SINGLE;
      default: scan_class = MULTI;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cand  <= 4'd0;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    accept  = 1'b0;
    if (scan_done) begin
      unique case (state)
        IDLE: begin
          if (scan_class == SINGLE) begin
            cand_n = scan_code;
            cnt_n  = 4'd1;
            if (DS_CNT <= 4'd1) begin
              accept  = 1'b1;
              state_n = HELD;
            end else begin
              state_n = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (scan_class != SINGLE) begin
            state_n = IDLE;
          end else if (scan_code == cand) begin
            cnt_n = cnt + 4'd1;
            if (cnt_n >= DS_CNT) begin
              accept  = 1'b1;
              state_n = HELD;
            end
          end else begin
            cand_n = scan_code;
            cnt_n  = 4'd1;
          end
        end
        HELD: begin
          // No rollover: extra keys while held are ignored until full release.
          if (scan_class == NONE) begin
            cnt_n   = 4'd1;
            state_n = (DS_CNT <= 4'd1) ? IDLE : RELEASE;
          end
        end
        RELEASE: begin
          if (scan_class == NONE) begin
            cnt_n = cnt + 4'd1;
            if (cnt_n >= DS_CNT) state_n = IDLE;
          end else begin
            state_n = HELD;
          end
        end
      endcase
    end
  end

  // clear has priority over an accept for the operand, but the key report
  // itself still updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_valid   <= 1'b0;
      key_code    <= 4'd0;
      value       <= 32'd0;
      digit_count <= 4'd0;
    end else begin
      key_valid <= accept;
      if (accept) key_code <= cand_n;
      if (clear) begin
        value       <= 32'd0;
        digit_count <= 4'd0;
      end else if (accept) begin
        value <= {value[27:0], cand_n};
        if (digit_count < MAX_DIGITS) digit_count <= digit_count + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Self-checking bench: a keypad model drives rows from col, and a digit-entry
// model (shift queue arithmetic) predicts key reports and the operand.
module tb_hex_keypad_entry;

  localparam int SCAN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic        clear;
  logic [3:0]  col;
  logic [31:0] value;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [3:0]  digit_count;

  logic [15:0] keys;
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          pulses = 0;

  logic [31:0] exp_value;
  logic [3:0]  exp_count;
  logic [3:0]  exp_code;
  int          exp_pulses;

  hex_keypad_entry #(.SCAN_DIV_W(3), .DEBOUNCE_SCANS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .row         (row),
    .clear       (clear),
    .col         (col),
    .value       (value),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .digit_count (digit_count)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!col[c])
        for (int r = 0; r < 4; r++)
          if (keys[r * 4 + c]) row[r] = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (key_valid) pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input logic [3:0] code);
    exp_pulses++;
    exp_code  = code;
    exp_value = {exp_value[27:0], code};
    if (exp_count < 4'd8) exp_count++;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pulses"}, pulses, exp_pulses);
    check({tag, "_code"}, {28'd0, key_code}, {28'd0, exp_code});
    check({tag, "_value"}, value, exp_value);
    check({tag, "_count"}, {28'd0, digit_count}, {28'd0, exp_count});
  endtask

  // Returns on the negedge right after the column drive wraps back to column 0.
  task automatic align_scan();
    logic [3:0] prev;
    logic       found;
    found = 1'b0;
    prev  = col;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (col == 4'b1110 && prev == 4'b0111) found = 1'b1;
      prev = col;
    end
    check("scan_align", {31'd0, found}, 32'd1);
  endtask

  task automatic wait_scans(input int n);
    repeat (n * SCAN) @(negedge clk);
  endtask

  task automatic key_at(input int r, input int c, input int hold);
    keys = '0;
    keys[r * 4 + c] = 1'b1;
    wait_scans(hold);
    keys = '0;
    wait_scans(6);
  endtask

  initial begin
    logic [3:0] code;
    rst = 1'b1;
    clear = 1'b0;
    keys = '0;
    exp_value = 0; exp_count = 0; exp_code = 0; exp_pulses = 0;
    repeat (3) @(negedge clk);
    check("rst_col", {28'd0, col}, 32'he);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check_model("rst");
    rst = 1'b0;

    // Single press of row1/col2.
    align_scan();
    key_at(1, 2, 6);
    model_accept(4'h6);
    check_model("press6");

    // Bounce: 2 scans pressed, 1 released, then stable; accept on 4th stable scan.
    align_scan();
    keys = 16'd1 << 1;
    wait_scans(2);
    keys = '0;
    wait_scans(1);
    keys = 16'd1 << 1;
    wait_scans(3);
    check("bounce_early", pulses, exp_pulses);
    wait_scans(1);
    check("bounce_valid", {31'd0, key_valid}, 32'd1);
    check("bounce_code", {28'd0, key_code}, 32'h1);
    wait_scans(1);
    keys = '0;
    wait_scans(6);
    model_accept(4'h1);
    check_model("bounce");

    // Reset mid-debounce, then column walk from reset.
    align_scan();
    keys = 16'd1 << 5;
    wait_scans(2);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_col", {28'd0, col}, 32'he);
    check("midrst_value", value, 32'd0);
    check("midrst_count", {28'd0, digit_count}, 32'd0);
    check("midrst_valid", {31'd0, key_valid}, 32'd0);
    keys = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_value = 0; exp_count = 0; exp_code = 0;
    for (int k = 0; k < 4; k++) begin
      repeat ((k == 0) ? 4 : 8) @(negedge clk);
      check($sformatf("col_walk%0d", k), {28'd0, col}, {28'd0, ~(4'b0001 << k)});
    end
    wait_scans(6);
    check_model("midrst");

    // Codes 1..9: digit count saturates and the oldest digit drops out.
    for (int d = 1; d <= 9; d++) begin
      code = 4'(d);
      align_scan();
      key_at(int'(code[3:2]), int'(code[1:0]), 6);
      model_accept(code);
    end
    check_model("nine_digits");
    check("nine_value_const", value, 32'h23456789);

    // Two keys together never accept; a lone key afterwards does.
    align_scan();
    keys = (16'd1 << 0) | (16'd1 << 11);
    wait_scans(10);
    check("multi_none", pulses, exp_pulses);
    keys = '0;
    key_at(3, 3, 6);
    model_accept(4'hF);
    check_model("after_multi");

    // clear in the same clk as the accept of code A.
    align_scan();
    keys = 16'd1 << 10;
    repeat (4 * SCAN - 1) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_accept(4'hA);
    exp_value = 0;
    exp_count = 0;
    check("clr_acc_valid", {31'd0, key_valid}, 32'd1);
    check_model("clr_acc");
    wait_scans(2);
    keys = '0;
    wait_scans(6);
    check_model("clr_acc_rel");

    // Randomized entry with unaligned presses and occasional clears.
    for (int k = 0; k < 12; k++) begin
      code = 4'($urandom_range(15, 0));
      repeat ($urandom_range(31, 0)) @(negedge clk);
      key_at(int'(code[3:2]), int'(code[1:0]), int'($urandom_range(7, 5)));
      model_accept(code);
      if ($urandom_range(3, 0) == 0) begin
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_value = 0;
        exp_count = 0;
      end
      check_model($sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
